// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised architectural register file with a
// power-up clear sequencer and a per-register pending-write scoreboard.
// Three combinational read ports, one rising-edge write port. The top
// index (NREGS-1) is the PC slot: it holds no storage and reads r15.
// Optional feature macro: REGFILE_BYPASS_EN (write-through on reads).

// One architectural register plus its pending bit.
module regfile_scoreboard_cell #(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sweep,
  input  logic [AW-1:0]    ptr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             set_en,
  input  logic [AW-1:0]    sa,
  output logic [WIDTH-1:0] q,
  output logic             p
);
  localparam logic [AW-1:0] ME = AW'(IDX);

  // Storage is zeroed by the sweep, not by reset; reset only restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (sweep && ptr == ME)
        q <= '0;
      else if (wr_en && wa == ME)
        q <= wd;
    end
  end

  // Pending bit: a new issue beats a retiring writeback to the same register.
  always_ff @(posedge clk) begin
    if (!reset_n)
      p <= 1'b0;
    else if (set_en && sa == ME)
      p <= 1'b1;
    else if (wr_en && wa == ME)
      p <= 1'b0;
  end
endmodule

// One combinational read port with PC-slot decode and optional write-through.
module regfile_scoreboard_rport #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic                        ready,
  input  logic [AW-1:0]               ra,
  input  logic [NREGS-2:0][WIDTH-1:0] rf,
  input  logic [NREGS-2:0]            pend,
  input  logic [WIDTH-1:0]            r15,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wa,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd,
  output logic                        pnd
);
  localparam logic [AW-1:0] PC = AW'(NREGS - 1);

`ifndef REGFILE_BYPASS_EN
  // Without write-through the write-port inputs have no reader here.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wa, wd};
`endif

  // Outputs are forced to zero until the clear sweep has finished.
  always_comb begin
    rd  = '0;
    pnd = 1'b0;
    if (ready) begin
      if (ra == PC) begin
        rd = r15;
      end else begin
        rd  = rf[ra];
        pnd = pend[ra];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes the PC slot, so no extra guard needed.
        if (wr_en && wa == ra)
          rd = wd;
`endif
      end
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             pend1,
  output logic             pend2,
  output logic             pend3,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             set_pend,
  input  logic [AW-1:0]    set_addr,
  input  logic [WIDTH-1:0] r15,
  output logic             busy
);
  localparam int NST = NREGS - 1;
  localparam int NRP = 3;
  localparam logic [AW-1:0] PC   = AW'(NREGS - 1);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 2);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                     state;
  logic [AW-1:0]              ptr;
  logic [NST-1:0][WIDTH-1:0]  rf;
  logic [NST-1:0]             pend;
  logic                       ready;
  logic                       wr_en;
  logic                       set_en;
  logic [NRP-1:0][AW-1:0]     ra_v;
  logic [NRP-1:0][WIDTH-1:0]  rd_v;
  logic [NRP-1:0]             pnd_v;

  assign ready  = (state == READY);
  // Writes and issues are ignored during the sweep; PC-slot writes are dropped.
  assign wr_en  = ready && we3 && (wa3 != PC);
  assign set_en = ready && set_pend && (set_addr != PC);

  // Clear sequencer: walk ptr over every stored register, then sit in READY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NST; i++) begin : g_reg
      regfile_scoreboard_cell #(.WIDTH(WIDTH), .AW(AW), .IDX(i)) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .sweep   (!ready),
        .ptr     (ptr),
        .wr_en   (wr_en),
        .wa      (wa3),
        .wd      (wd3),
        .set_en  (set_en),
        .sa      (set_addr),
        .q       (rf[i]),
        .p       (pend[i])
      );
    end

    for (genvar j = 0; j < NRP; j++) begin : g_rport
      regfile_scoreboard_rport #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rport (
        .ready (ready),
        .ra    (ra_v[j]),
        .rf    (rf),
        .pend  (pend),
        .r15   (r15),
        .wr_en (wr_en),
        .wa    (wa3),
        .wd    (wd3),
        .rd    (rd_v[j]),
        .pnd   (pnd_v[j])
      );
    end
  endgenerate

  assign ra_v  = {ra3, ra2, ra1};
  assign rd1   = rd_v[0];
  assign rd2   = rd_v[1];
  assign rd3   = rd_v[2];
  assign pend1 = pnd_v[0];
  assign pend2 = pnd_v[1];
  assign pend3 = pnd_v[2];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus a randomized run,
// all checked against an array-based model of the architectural state.
module tb_regfile_scoreboard;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] ra1, ra2, ra3, wa3, set_addr;
  logic          we3, set_pend;
  logic [W-1:0]  wd3, r15;
  logic [W-1:0]  rd1, rd2, rd3;
  logic          pend1, pend2, pend3, busy;

  int checks = 0;
  int errors = 0;

  // Model: register values, pending flags, remaining busy cycles.
  logic [W-1:0] m_rf [N-1];
  bit           m_pend [N-1];
  int           busy_left = N - 1;

  regfile_scoreboard #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .pend1(pend1), .pend2(pend2), .pend3(pend3),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .set_pend(set_pend), .set_addr(set_addr),
    .r15(r15), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] ra);
    if (busy_left > 0) return '0;
    if (ra == AW'(N - 1)) return r15;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == ra) return wd3;
`endif
    return m_rf[ra];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] ra);
    if (busy_left > 0 || ra == AW'(N - 1)) return 1'b0;
    return m_pend[ra];
  endfunction

  // Advance one clock, applying the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      busy_left = N - 1;
      for (int i = 0; i < N - 1; i++) begin
        m_rf[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we3 && wa3 != AW'(N - 1)) begin
        m_rf[wa3] = wd3;
        if (!(set_pend && set_addr == wa3)) m_pend[wa3] = 1'b0;
      end
      if (set_pend && set_addr != AW'(N - 1)) m_pend[set_addr] = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 0; set_pend = 0; wa3 = 0; wd3 = 0; set_addr = 0;
  endtask

  task automatic test_reset();
    int busy_cycles = 0;
    reset_n = 0; idle(); ra1 = 0; ra2 = 0; ra3 = 0; r15 = 32'h100;
    tick(); tick();
    checks++;
    if (busy !== 1'b1 || rd1 !== '0 || pend1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b rd1=%h pend1=%b want 1/0/0", busy, rd1, pend1);
    end
    reset_n = 1;
    for (int c = 0; c < 20; c++) begin
      ra1 = AW'($urandom_range(0, N - 1)); ra2 = AW'(c % N);
      #1;
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (busy !== (busy_left > 0) || {pend1, pend2, pend3} !== 3'b000) begin
        errors++;
        $display("FAIL reset_busy cyc=%0d busy=%b pend=%b%b%b want busy=%0d pend=000",
                 c, busy, pend1, pend2, pend3, busy_left > 0);
      end
      tick();
    end
    checks++;
    if (busy_cycles != N - 1) begin
      errors++;
      $display("FAIL reset_busy_len got %0d want %0d", busy_cycles, N - 1);
    end
    for (int i = 0; i < N - 1; i++) begin
      ra1 = AW'(i); ra2 = AW'(i); ra3 = AW'(i);
      #1;
      checks++;
      if (rd1 !== '0 || rd2 !== '0 || rd3 !== '0 || {pend1, pend2, pend3} !== 3'b000) begin
        errors++;
        $display("FAIL reset_zero reg=%0d rd=%h/%h/%h want 0", i, rd1, rd2, rd3);
      end
    end
  endtask

  task automatic test_write_read();
    we3 = 1; wa3 = 5; wd3 = 32'hDEADBEEF;
    tick();
    idle(); ra2 = 5; ra1 = 15; r15 = 32'h100;
    #1;
    checks++;
    if (rd2 !== 32'hDEADBEEF || rd1 !== 32'h100) begin
      errors++;
      $display("FAIL write_read rd2=%h rd1=%h want deadbeef/00000100", rd2, rd1);
    end
    we3 = 1; wa3 = 15; wd3 = 32'h1234;
    tick();
    idle(); ra1 = 15;
    #1;
    checks++;
    if (rd1 !== 32'h100 || rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pc_write_drop rd1=%h rd2=%h want 00000100/deadbeef", rd1, rd2);
    end
    for (int i = 0; i < N - 1; i++) begin
      ra3 = AW'(i);
      #1;
      checks++;
      if (rd3 !== exp_rd(ra3)) begin
        errors++;
        $display("FAIL pc_write_side reg=%0d got %h want %h", i, rd3, exp_rd(ra3));
      end
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    we3 = 1; wa3 = 3; wd3 = 32'h11;
    tick();
    we3 = 1; wa3 = 3; wd3 = 32'h22; ra3 = 3;
`ifdef REGFILE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    #1;
    checks++;
    if (rd3 !== want) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want %h", rd3, want);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd3 !== 32'h22) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h want 00000022", rd3);
    end
  endtask

  task automatic test_scoreboard();
    set_pend = 1; set_addr = 7;
    tick();
    idle(); ra1 = 7;
    #1;
    checks++;
    if (pend1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_set got %b want 1", pend1);
    end
    we3 = 1; wa3 = 7; wd3 = $urandom;
    #1;
    checks++;
    if (pend1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_no_bypass got %b want 1", pend1);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pend1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear got %b want 0", pend1);
    end
    set_pend = 1; set_addr = 7; we3 = 1; wa3 = 7; wd3 = $urandom;
    tick();
    idle();
    #1;
    checks++;
    if (pend1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins got %b want 1", pend1);
    end
    set_pend = 1; set_addr = 15;
    tick();
    idle(); ra2 = 15;
    #1;
    checks++;
    if (pend2 !== 1'b0) begin
      errors++;
      $display("FAIL sb_pc_slot got %b want 0", pend2);
    end
  endtask

  task automatic test_clear_writes();
    int guard = 0;
    reset_n = 0; idle();
    tick();
    reset_n = 1;
    we3 = 1; wa3 = 2; wd3 = 32'h55; set_pend = 1; set_addr = 2;
    while (busy_left > 0 && guard < 40) begin
      tick();
      guard++;
    end
    idle(); ra1 = 2;
    #1;
    checks++;
    if (busy !== 1'b0 || rd1 !== '0 || pend1 !== 1'b0) begin
      errors++;
      $display("FAIL clear_ignores busy=%b rd1=%h pend1=%b want 0/0/0", busy, rd1, pend1);
    end
  endtask

  task automatic test_reset_mid();
    int busy_cycles = 0;
    for (int i = 0; i < N - 1; i++) begin
      we3 = 1; wa3 = AW'(i); wd3 = $urandom | 32'h1;
      set_pend = 1; set_addr = AW'((i + 1) % (N - 1));
      tick();
    end
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy === 1'b1) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != N - 1) begin
      errors++;
      $display("FAIL mid_reset_busy got %0d want %0d", busy_cycles, N - 1);
    end
    for (int i = 0; i < N - 1; i++) begin
      ra1 = AW'(i); ra2 = AW'(i); ra3 = AW'(i);
      #1;
      checks++;
      if (rd1 !== '0 || rd2 !== '0 || rd3 !== '0 || {pend1, pend2, pend3} !== 3'b000) begin
        errors++;
        $display("FAIL mid_reset_zero reg=%0d rd=%h pend=%b%b%b want 0", i, rd1,
                 pend1, pend2, pend3);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ra1 = AW'($urandom_range(0, N - 1));
      ra2 = AW'($urandom_range(0, N - 1));
      ra3 = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, N - 1));
      we3 = ($urandom_range(0, 1) == 1);
      wa3 = AW'($urandom_range(0, N - 1));
      wd3 = $urandom;
      set_pend = ($urandom_range(0, 2) == 0);
      set_addr = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom_range(0, N - 1));
      r15 = $urandom;
      if ($urandom_range(0, 2) == 0) ra3 = wa3;
      #1;
      checks++;
      if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) || rd3 !== exp_rd(ra3) ||
          pend1 !== exp_pend(ra1) || pend2 !== exp_pend(ra2) || pend3 !== exp_pend(ra3)) begin
        errors++;
        $display("FAIL random cyc=%0d rd=%h/%h/%h pend=%b%b%b want rd=%h/%h/%h pend=%b%b%b",
                 c, rd1, rd2, rd3, pend1, pend2, pend3,
                 exp_rd(ra1), exp_rd(ra2), exp_rd(ra3),
                 exp_pend(ra1), exp_pend(ra2), exp_pend(ra3));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_random();
    test_clear_writes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
